burst_source: RTL and testbench

Upstream beat generator for the AXI4 handshake chain. It accepts one burst command (base value, beat count) and emits an incrementing-data burst on a valid/ready/last interface. It feeds the data/valid inputs of the ready register slice and takes back its ready output. All source-side AXI rules are met: valid is never withdrawn and data is never changed while a beat is pending.

---
 rtl/burst_source_if.sv | 38 +++
 rtl/burst_source.sv | 102 ++++++++++
 tb/tb_burst_source.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/burst_source_if.sv
// rtl/burst_source_if.sv - command and beat-stream bundle for burst_source
//
// Purpose: groups the command handshake, the pause request and the outgoing
// valid/ready/last beat stream of burst_source into one interface.
//   master : view taken by burst_source (drives cmd_ready and the beat outputs)
//   slave  : view taken by whatever issues commands and consumes the beats
// Signals:
//   cmd_valid/cmd_ready/cmd_base/cmd_len : burst command handshake
//   pause                                : request bubbles between beats
//   data_out/valid_out/last_out/ready_in : beat stream
//   done                                 : one-cycle pulse after final beat
//   beat_idx                             : index of the beat being presented
interface burst_source_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_base;
  logic [LEN_W-1:0]  cmd_len;
  logic              pause;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              last_out;
  logic              ready_in;
  logic              done;
  logic [LEN_W-1:0]  beat_idx;

  modport master (
    input  cmd_valid, cmd_base, cmd_len, pause, ready_in,
    output cmd_ready, data_out, valid_out, last_out, done, beat_idx
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_len, pause, ready_in,
    input  cmd_ready, data_out, valid_out, last_out, done, beat_idx
  );
endinterface

// File: rtl/burst_source.sv
// rtl/burst_source.sv - incrementing-data burst generator on a valid/ready/last stream
//
// Purpose: accepts one (base, len) command at a time and emits len+1 beats
// with data base, base+1, ... (wrapping modulo 2^DATA_W). Valid is never
// withdrawn and data never changes while a beat is pending.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : burst_source_if.master (command, pause, beat stream, done, beat_idx)
// All outputs are registered; nothing combinational reaches them from
// ready_in or cmd_valid.
module burst_source #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input logic            clk,
  input logic            rst,
  burst_source_if.master bus
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [LEN_W-1:0]  IDX_ONE  = LEN_W'(1);
  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_idx_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              last_q;
  logic              done_q;
  logic              cmd_ready_q;

  logic hs;
  logic at_last;

  assign hs      = valid_q & bus.ready_in;
  assign at_last = (beat_idx_q == len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      beat_idx_q  <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            // beat 0 is presented straight from the command fields
            len_q       <= bus.cmd_len;
            beat_idx_q  <= '0;
            data_q      <= bus.cmd_base;
            valid_q     <= 1'b1;
            last_q      <= (bus.cmd_len == '0);
            cmd_ready_q <= 1'b0;
            state       <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            if (at_last) begin
              valid_q     <= 1'b0;
              last_q      <= 1'b0;
              done_q      <= 1'b1;
              cmd_ready_q <= 1'b1;
              state       <= IDLE;
            end else begin
              // data tracks base + beat_idx by incrementing alongside the index
              beat_idx_q <= beat_idx_q + IDX_ONE;
              data_q     <= data_q + DATA_ONE;
              valid_q    <= ~bus.pause;
              last_q     <= ~bus.pause & ((beat_idx_q + IDX_ONE) == len_q);
            end
          end else if (!valid_q) begin
            // bubble inserted by pause: re-present the same beat once released
            if (!bus.pause) begin
              valid_q <= 1'b1;
              last_q  <= at_last;
            end
          end
          // valid_q high with ready_in low: everything holds
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.last_out  = last_q;
  assign bus.done      = done_q;
  assign bus.beat_idx  = beat_idx_q;

endmodule

// File: tb/tb_burst_source.sv
// tb/tb_burst_source.sv - scoreboard testbench for burst_source
module tb_burst_source;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  burst_source_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bif ();

  burst_source #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [7:0]  idx;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec  = 0;
  int    n_fail = 0;
  int    cyc    = 0;
  bit    rand_en = 1'b0;

  // monitor-side model state
  bit          exp_idle = 1'b1;
  bit          exp_done = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] stall_data = '0;
  int          prev_last_cyc = 0;
  int          last_gap = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_burst(logic [31:0] base, int len);
    beat_t b;
    for (int i = 0; i <= len; i++) begin
      b.data = base + 32'(i);
      b.last = (i == len);
      b.idx  = 8'(i);
      exp_q.push_back(b);
    end
  endfunction

  // Monitor: samples at the falling edge, between the driver's updates.
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      exp_idle   = 1'b1;
      exp_done   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      chk("cmd_ready", 32'(bif.cmd_ready), 32'(exp_idle));
      chk("done", 32'(bif.done), 32'(exp_done));
      if (exp_idle) chk("idle_valid", 32'(bif.valid_out), 32'd0);
      if (stall_prev) begin
        chk("stall_valid", 32'(bif.valid_out), 32'd1);
        chk("stall_data", bif.data_out, stall_data);
      end
      exp_done = 1'b0;
      if (exp_idle) begin
        if (bif.cmd_valid) exp_idle = 1'b0;
      end else if (bif.valid_out && bif.ready_in) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(bif.valid_out), 32'd0);
        end else begin
          b = exp_q.pop_front();
          chk("data", bif.data_out, b.data);
          chk("last", 32'(bif.last_out), 32'(b.last));
          chk("beat_idx", 32'(bif.beat_idx), 32'(b.idx));
          if (b.idx == 8'd0) last_gap = cyc - prev_last_cyc;
          if (b.last) begin
            prev_last_cyc = cyc;
            exp_idle = 1'b1;
            exp_done = 1'b1;
          end
        end
      end
      stall_prev = bif.valid_out && !bif.ready_in;
      stall_data = bif.data_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_en) begin
      bif.ready_in = ($urandom_range(0, 3) != 0);
      bif.pause    = ($urandom_range(0, 4) == 0);
    end
  endtask

  task automatic issue(logic [31:0] base, int len, bit hold);
    int n = 0;
    bif.cmd_base  = base;
    bif.cmd_len   = 8'(len);
    bif.cmd_valid = 1'b1;
    while (bif.cmd_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk("cmd_accept_timeout", 32'(n), 32'd0);
    push_burst(base, len);
    tick();
    if (!hold) bif.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(exp_q.size() == 0 && bif.cmd_ready === 1'b1 && bif.cmd_valid == 1'b0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_valid"}, 32'(bif.valid_out), 32'd0);
    chk({tag, "_last"}, 32'(bif.last_out), 32'd0);
    chk({tag, "_data"}, bif.data_out, 32'd0);
    chk({tag, "_idx"}, 32'(bif.beat_idx), 32'd0);
    chk({tag, "_done"}, 32'(bif.done), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(bif.cmd_ready), 32'd1);
  endtask

  initial begin
    int n;
    int len;
    logic [31:0] base;
    bif.cmd_valid = 1'b0;
    bif.cmd_base  = '0;
    bif.cmd_len   = '0;
    bif.pause     = 1'b0;
    bif.ready_in  = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("reset");

    // basic burst
    issue(32'h100, 3, 1'b0);
    wait_idle();

    // backpressure: beat 0 held five cycles
    bif.ready_in = 1'b0;
    issue(32'h10, 1, 1'b0);
    repeat (5) begin
      chk("bp_valid", 32'(bif.valid_out), 32'd1);
      chk("bp_data", bif.data_out, 32'h10);
      tick();
    end
    bif.ready_in = 1'b1;
    wait_idle();

    // pause after the first handshake gives exactly two bubbles
    issue(32'h200, 2, 1'b0);
    bif.pause = 1'b1;
    tick();
    chk("pause_bubble1", 32'(bif.valid_out), 32'd0);
    tick();
    chk("pause_bubble2", 32'(bif.valid_out), 32'd0);
    bif.pause = 1'b0;
    tick();
    chk("pause_resume_valid", 32'(bif.valid_out), 32'd1);
    chk("pause_resume_idx", 32'(bif.beat_idx), 32'd1);
    wait_idle();

    // pause while stalled must not drop valid
    issue(32'h300, 1, 1'b0);
    bif.ready_in = 1'b0;
    bif.pause    = 1'b1;
    repeat (3) tick();
    chk("stall_pause_valid", 32'(bif.valid_out), 32'd1);
    chk("stall_pause_data", bif.data_out, 32'h300);
    bif.ready_in = 1'b1;
    bif.pause    = 1'b0;
    wait_idle();

    // single-beat burst
    issue(32'h55, 0, 1'b0);
    chk("len0_last", 32'(bif.last_out), 32'd1);
    wait_idle();

    // data wrap
    issue(32'hFFFF_FFFE, 3, 1'b0);
    wait_idle();

    // longest burst
    issue($urandom, 255, 1'b0);
    wait_idle();

    // back-to-back commands with cmd_valid held
    issue(32'h1000, 2, 1'b1);
    issue(32'h2000, 1, 1'b1);
    bif.cmd_valid = 1'b0;
    wait_idle();
    chk("b2b_gap", 32'(last_gap), 32'd2);

    // reset during beat 2 of an 8-beat burst
    issue(32'h700, 7, 1'b0);
    n = 0;
    while (!(bif.valid_out && bif.beat_idx == 8'd2) && n < 50) begin
      tick();
      n++;
    end
    chk("mid_reset_reach_beat2", 32'(bif.beat_idx), 32'd2);
    rst = 1'b1;
    tick();
    check_reset("mid_reset");
    rst = 1'b0;
    exp_q.delete();
    tick();
    chk("mid_reset_no_done", 32'(bif.done), 32'd0);
    issue(32'h800, 3, 1'b0);
    wait_idle();

    // randomized commands, ready and pause
    rand_en = 1'b1;
    repeat (40) begin
      len  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
      base = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
      issue(base, len, 1'(($urandom_range(0, 2) == 0)));
      if ($urandom_range(0, 1) == 0) begin
        bif.cmd_valid = 1'b0;
        wait_idle();
      end
    end
    bif.cmd_valid = 1'b0;
    wait_idle();
    rand_en = 1'b0;
    bif.ready_in = 1'b1;
    bif.pause    = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
